seven_seg_scanner: RTL and testbench
====================================

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 The block SHALL take parameter NUM_DIGITS, default 4, meaning the number of multiplexed digits (legal range 1..8).
REQ-002 The block SHALL take parameter REFRESH_DIV, default 50000, meaning clocks per digit slot (multiple of 16, at least 32).
REQ-003 The block SHALL take parameter GUARD_CYCLES, default 2, meaning anode-off cycles at the start of each slot (less than REFRESH_DIV/16).
REQ-004 The block SHALL take parameter ANODE_ACTIVE_LOW, default 1, meaning anode_o polarity (1 = active-low).
REQ-005 The block SHALL take parameter SEG_ACTIVE_LOW, default 1, meaning seg_o/dp_o polarity (1 = active-low).
REQ-006 clk  in  1  single clock; all state on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 en  in  1  scan enable.
REQ-009 digits_i  in  4*NUM_DIGITS  4-bit hex codes; bits [3:0] = digit 0 (least significant).
REQ-010 dp_i  in  NUM_DIGITS  decimal point per digit, 1 = lit.
REQ-011 brightness_i  in  4  duty level 0..15.
REQ-012 lz_blank_en  in  1  leading-zero blanking enable.
REQ-013 anode_o  out  NUM_DIGITS  one-hot digit drive, polarity per ANODE_ACTIVE_LOW.
REQ-014 seg_o  out  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
REQ-015 dp_o  out  1  decimal point, polarity per SEG_ACTIVE_LOW.
REQ-016 digit_idx_o  out  $clog2(NUM_DIGITS) (min 1)  index of the current slot.
REQ-017 frame_tick_o  out  1  one-cycle pulse when a new frame starts.

Function
REQ-018 The prescaler SHALL count 0..REFRESH_DIV-1 while en=1; at REFRESH_DIV-1 it SHALL wrap to 0 and advance digit_idx.
REQ-019 digit_idx SHALL advance from NUM_DIGITS-1 to 0 (wrap); with NUM_DIGITS=1 it stays 0.
REQ-020 frame_tick_o SHALL pulse for exactly one cycle, in the cycle digit_idx becomes 0 through a wrap.
REQ-021 Snapshot: in the frame_tick_o cycle, digits_i, dp_i, brightness_i and lz_blank_en SHALL be latched; all display output uses only the snapshot (no tearing within a frame).
REQ-022 on_limit SHALL be ((brightness+1)*REFRESH_DIV)>>4, computed from the snapshot.
REQ-023 The current anode SHALL be active iff en=1, GUARD_CYCLES <= prescaler < on_limit, and the digit is not blanked; all other anodes SHALL be inactive.
REQ-024 Decode: codes 0-9 SHALL produce standard digits, and codes 10-15 SHALL produce A,b,C,d,E,F.
REQ-025 Leading-zero blanking: with lz_blank_en=1, digit i>0 SHALL be blanked (anode inactive) when it and all more-significant digits are 0; digit 0 is never blanked.
REQ-026 anode_o, seg_o and dp_o SHALL be registered, with 1-cycle latency from prescaler/digit_idx state.
REQ-027 en=0 SHALL hold the prescaler and digit_idx, force all anodes inactive from the next cycle, and suppress frame_tick_o.
REQ-028 Re-assertion of en SHALL resume counting from the held values.
REQ-029 Live input changes mid-frame SHALL have no effect until the next frame_tick_o.

Reset
REQ-030 rst_n=0 SHALL immediately clear the prescaler, digit_idx, the snapshot (all zero, brightness 0) and frame_tick_o.
REQ-031 rst_n=0 SHALL immediately drive all anodes and segments and dp_o inactive at the configured polarity.
REQ-032 After reset release, the first frame_tick_o SHALL occur at the first wrap from NUM_DIGITS-1 to 0, so the first frame displays the zero snapshot.

Structure
REQ-033 Package seg_pkg SHALL hold the 16-entry segment-pattern constants and the SEG_BLANK constant.
REQ-034 Sub-module seg_decoder (combinational, 4-bit code to 7-bit active-high pattern) SHALL be instantiated once; polarity inversion SHALL be applied at the output registers.

Verification (NUM_DIGITS=4, REFRESH_DIV=32, GUARD_CYCLES=2, active-low)
REQ-035 Reset mid-scan: assert rst_n low at prescaler 17, digit 2 -> anode_o=4'b1111, seg_o=7'h7F, dp_o=1, digit_idx_o=0 immediately.
REQ-036 Scan order: digits_i=16'h1234, brightness 15 -> after the first frame, each anode is low 30 of every 32 cycles, order idx0..3; seg codes 4,3,2,1; frame_tick_o every 128 cycles.
REQ-037 Brightness: brightness_i=7 -> anode low for prescaler 2..15 (14 cycles) per slot; brightness_i=0 -> prescaler 2..1, so never lit.
REQ-038 Blanking: digits_i=16'h0050, lz_blank_en=1 -> digits 3 and 2 never lit, digit 1 shows 5, digit 0 shows 0; with lz_blank_en=0, all four are lit.
REQ-039 Snapshot: change digits_i from 16'h1111 to 16'h2222 mid-frame -> seg_o shows 1 until the next frame_tick_o, then 2.
REQ-040 Enable: deassert en at digit 1, prescaler 10, for 50 cycles -> anodes inactive, digit_idx_o held at 1; on re-enable, counting resumes at prescaler 10.

Source files
------------

// File: rtl/seg_pkg.sv
// Seven-segment pattern constants shared by the scanner and its decoder.
package seg_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned CODE_W = 4;

  // Active-high patterns, bit order {g,f,e,d,c,b,a}; entry n is code n.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h71,  // F
    7'h79,  // E
    7'h5E,  // d
    7'h39,  // C
    7'h7C,  // b
    7'h77,  // A
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  // All segments dark, active-high.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_decoder.sv
// Combinational hex-code to active-high seven-segment pattern lookup.
module seg_decoder
  import seg_pkg::*;
(
  input  logic [CODE_W-1:0] code_i,
  output logic [SEG_W-1:0]  pattern_c_o
);

  // Table lookup; every 4-bit code has a glyph.
  always_comb begin
    pattern_c_o = SEG_TABLE[code_i];
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment scanner with per-frame input snapshot,
// PWM brightness, anode guard time and leading-zero blanking.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned REFRESH_DIV      = 50000,
  parameter int unsigned GUARD_CYCLES     = 2,
  parameter int unsigned ANODE_ACTIVE_LOW = 1,
  parameter int unsigned SEG_ACTIVE_LOW   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [4*NUM_DIGITS-1:0]       digits_i,
  input  logic [NUM_DIGITS-1:0]         dp_i,
  input  logic [3:0]                    brightness_i,
  input  logic                          lz_blank_en,
  output logic [NUM_DIGITS-1:0]         anode_o,
  output logic [SEG_W-1:0]              seg_o,
  output logic                          dp_o,
  output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx_o,
  output logic                          frame_tick_o
);

  localparam int unsigned PRESC_W   = $clog2(REFRESH_DIV);
  localparam int unsigned IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SLOT_STEP = REFRESH_DIV / 16;

  localparam logic [NUM_DIGITS-1:0] ANODE_POL = (ANODE_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [SEG_W-1:0]      SEG_POL   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_POL    = (SEG_ACTIVE_LOW != 0);

  logic [PRESC_W-1:0]      presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    tick_q, tick_d;
  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic [3:0]              snap_bright_q, snap_bright_d;
  logic                    snap_lz_q, snap_lz_d;
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [SEG_W-1:0]        seg_q, seg_d;
  logic                    dp_q, dp_d;

  logic [CODE_W-1:0]       cur_code;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [SEG_W-1:0]        cur_pattern;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    zero_above;
  logic [31:0]             on_limit;
  logic                    lit;
  logic [NUM_DIGITS-1:0]   anode_act;

  // Prescaler, slot index, frame tick and the frame-boundary snapshot.
  always_comb begin
    presc_d       = presc_q;
    idx_d         = idx_q;
    tick_d        = 1'b0;
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    snap_bright_d = snap_bright_q;
    snap_lz_d     = snap_lz_q;
    if (en) begin
      if (presc_q == PRESC_W'(REFRESH_DIV - 1)) begin
        presc_d = '0;
        if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
          // New frame: the snapshot becomes visible together with the tick.
          idx_d         = '0;
          tick_d        = 1'b1;
          snap_digits_d = digits_i;
          snap_dp_d     = dp_i;
          snap_bright_d = brightness_i;
          snap_lz_d     = lz_blank_en;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        presc_d = presc_q + PRESC_W'(1);
      end
    end
  end

  // Leading-zero blank mask from the snapshot; digit 0 is always shown.
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      zero_above = zero_above & (snap_digits_q[i*4 +: 4] == 4'h0);
      blank[i]   = snap_lz_q & zero_above;
    end
  end

  // Select the snapshot data for the current slot.
  always_comb begin
    cur_code  = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_code  = snap_digits_q[i*4 +: 4];
        cur_dp    = snap_dp_q[i];
        cur_blank = blank[i];
      end
    end
  end

  seg_decoder u_seg_decoder (
    .code_i      (cur_code),
    .pattern_c_o (cur_pattern)
  );

  // Anode window (guard + PWM duty) and polarity-adjusted output next values.
  always_comb begin
    on_limit = (32'(snap_bright_q) + 32'd1) * SLOT_STEP;
    lit      = en && (32'(presc_q) >= GUARD_CYCLES) && (32'(presc_q) < on_limit)
               && !cur_blank;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      anode_act[i] = lit && (idx_q == IDX_W'(i));
    end
    anode_d = anode_act ^ ANODE_POL;
    seg_d   = cur_pattern ^ SEG_POL;
    dp_d    = cur_dp ^ DP_POL;
  end

  // State and output registers; reset leaves every driver inactive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      idx_q         <= '0;
      tick_q        <= 1'b0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      snap_bright_q <= '0;
      snap_lz_q     <= 1'b0;
      anode_q       <= ANODE_POL;
      seg_q         <= SEG_BLANK ^ SEG_POL;
      dp_q          <= DP_POL;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      tick_q        <= tick_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      snap_bright_q <= snap_bright_d;
      snap_lz_q     <= snap_lz_d;
      anode_q       <= anode_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign anode_o      = anode_q;
  assign seg_o        = seg_q;
  assign dp_o         = dp_q;
  assign digit_idx_o  = idx_q;
  assign frame_tick_o = tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench: each frame's expected lit windows are queued by the
// stimulus; the monitor measures every anode-active window and compares.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] digits;
  logic [3:0]  dp_in;
  logic [3:0]  bright;
  logic        lz;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp_out;
  logic [1:0]  idx;
  logic        tick;

  seven_seg_scanner #(
    .NUM_DIGITS       (4),
    .REFRESH_DIV      (32),
    .GUARD_CYCLES     (2),
    .ANODE_ACTIVE_LOW (1),
    .SEG_ACTIVE_LOW   (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .digits_i     (digits),
    .dp_i         (dp_in),
    .brightness_i (bright),
    .lz_blank_en  (lz),
    .anode_o      (anode),
    .seg_o        (seg),
    .dp_o         (dp_out),
    .digit_idx_o  (idx),
    .frame_tick_o (tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] sg;
    logic       dp;
    logic [7:0] len;
    logic       stable;
  } win_t;

  // Active-low glyphs
  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19, S5 = 7'h12;
  localparam logic [6:0] SA = 7'h08, SB = 7'h03, SC = 7'h46, SD = 7'h21;

  win_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  bit   in_win = 1'b0;
  bit   win_rep = 1'b0;
  win_t cur;
  win_t e;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  task automatic push(input logic [3:0] an, input logic [6:0] sg, input logic d, input int len);
    win_t w;
    w.an     = an;
    w.sg     = sg;
    w.dp     = d;
    w.len    = 8'(len);
    w.stable = 1'b1;
    exp_q.push_back(w);
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 1000);
    if (!tick) begin
      errors++;
      checks++;
      $display("FAIL tick_timeout: got no frame tick, required one within 1000 cycles");
    end
  endtask

  // Monitor: track each contiguous anode-active window and score it when it ends.
  always @(negedge clk) begin
    if (in_win && anode == cur.an) begin
      cur.len = cur.len + 8'd1;
      if (seg != cur.sg || dp_out != cur.dp) cur.stable = 1'b0;
    end else begin
      if (in_win) begin
        in_win = 1'b0;
        if (win_rep) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL window_unexpected: got an=%b seg=%h dp=%b len=%0d, required no lit window",
                     cur.an, cur.sg, cur.dp, cur.len);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              errors++;
              $display("FAIL window: got an=%b seg=%h dp=%b len=%0d stable=%b, required an=%b seg=%h dp=%b len=%0d stable=1",
                       cur.an, cur.sg, cur.dp, cur.len, cur.stable, e.an, e.sg, e.dp, e.len);
            end
          end
        end
      end
      if (anode != 4'hF) begin
        in_win     = 1'b1;
        win_rep    = mon_en;
        cur.an     = anode;
        cur.sg     = seg;
        cur.dp     = dp_out;
        cur.len    = 8'd1;
        cur.stable = 1'b1;
      end
    end
  end

  initial begin
    int n;
    int bad_an;
    int bad_idx;
    int bad_tick;

    rst_n  = 1'b1;
    en     = 1'b0;
    digits = 16'h1234;
    dp_in  = 4'b0010;
    bright = 4'd15;
    lz     = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("reset_anode", 32'(anode), 32'hF);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_dp", 32'(dp_out), 32'h1);
    check("reset_idx", 32'(idx), 32'h0);
    check("reset_tick", 32'(tick), 32'h0);

    // First frame after reset uses the all-zero snapshot: nothing lit.
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    en     = 1'b1;
    mon_en = 1'b1;
    wait_tick(n);
    check("first_tick_latency", 32'(n), 32'd128);
    check("tick_idx0", 32'(idx), 32'd0);

    // Frame: 1234, full brightness, dp on digit 1
    push(4'b1110, S4, 1'b1, 30);
    push(4'b1101, S3, 1'b0, 30);
    push(4'b1011, S2, 1'b1, 30);
    push(4'b0111, S1, 1'b1, 30);
    digits = 16'hDCBA;
    dp_in  = 4'b0000;
    wait_tick(n);
    check("frame_period", 32'(n), 32'd128);

    // Frame: hex letters
    push(4'b1110, SA, 1'b1, 30);
    push(4'b1101, SB, 1'b1, 30);
    push(4'b1011, SC, 1'b1, 30);
    push(4'b0111, SD, 1'b1, 30);
    digits = 16'h1234;
    bright = 4'd7;
    wait_tick(n);
    check("frame_period2", 32'(n), 32'd128);

    // Frame: brightness 7 -> 14-cycle windows
    push(4'b1110, S4, 1'b1, 14);
    push(4'b1101, S3, 1'b1, 14);
    push(4'b1011, S2, 1'b1, 14);
    push(4'b0111, S1, 1'b1, 14);
    bright = 4'd0;
    wait_tick(n);

    // Frame: brightness 0 -> nothing expected
    digits = 16'h0050;
    bright = 4'd15;
    lz     = 1'b1;
    wait_tick(n);

    // Frame: leading-zero blanking on
    push(4'b1110, S0, 1'b1, 30);
    push(4'b1101, S5, 1'b1, 30);
    lz = 1'b0;
    wait_tick(n);

    // Frame: blanking off, all four lit
    push(4'b1110, S0, 1'b1, 30);
    push(4'b1101, S5, 1'b1, 30);
    push(4'b1011, S0, 1'b1, 30);
    push(4'b0111, S0, 1'b1, 30);
    digits = 16'h1111;
    wait_tick(n);

    // Frame: snapshot holds 1111 despite a mid-frame change
    push(4'b1110, S1, 1'b1, 30);
    push(4'b1101, S1, 1'b1, 30);
    push(4'b1011, S1, 1'b1, 30);
    push(4'b0111, S1, 1'b1, 30);
    repeat (40) @(negedge clk);
    digits = 16'h2222;
    wait_tick(n);
    check("tick_after_change", 32'(n), 32'd88);

    push(4'b1110, S2, 1'b1, 30);
    push(4'b1101, S2, 1'b1, 30);
    push(4'b1011, S2, 1'b1, 30);
    push(4'b0111, S2, 1'b1, 30);
    digits = 16'h1234;
    wait_tick(n);

    // Frame: en dropped at digit 1, prescaler 10, for 50 cycles
    push(4'b1110, S4, 1'b1, 30);
    push(4'b1101, S3, 1'b1, 8);
    push(4'b1101, S3, 1'b1, 22);
    push(4'b1011, S2, 1'b1, 30);
    push(4'b0111, S1, 1'b1, 30);
    repeat (42) @(negedge clk);
    check("pre_disable_idx", 32'(idx), 32'd1);
    en       = 1'b0;
    bad_an   = 0;
    bad_idx  = 0;
    bad_tick = 0;
    repeat (50) begin
      @(negedge clk);
      if (anode != 4'hF) bad_an++;
      if (idx != 2'd1) bad_idx++;
      if (tick) bad_tick++;
    end
    check("disabled_anode_cycles", 32'(bad_an), 32'd0);
    check("disabled_idx_cycles", 32'(bad_idx), 32'd0);
    check("disabled_tick_cycles", 32'(bad_tick), 32'd0);
    en = 1'b1;
    wait_tick(n);
    check("resume_to_tick", 32'(n), 32'd86);
    mon_en = 1'b0;

    // Reset mid-scan at digit 2, prescaler 17
    repeat (81) @(negedge clk);
    check("pre_reset_idx", 32'(idx), 32'd2);
    #1 rst_n = 1'b0;
    #1;
    check("midreset_anode", 32'(anode), 32'hF);
    check("midreset_seg", 32'(seg), 32'h7F);
    check("midreset_dp", 32'(dp_out), 32'h1);
    check("midreset_idx", 32'(idx), 32'h0);
    check("midreset_tick", 32'(tick), 32'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    wait_tick(n);
    check("post_reset_tick_latency", 32'(n), 32'd128);
    mon_en = 1'b0;

    repeat (40) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
